// File: rtl/four_to_two_enc.sv
// four_to_two_enc: captures up to four request lines into a pending set and
// grants them one at a time as a 2-bit index with a valid/ready handshake.
// Optional feature macro: ROUND_ROBIN_EN
//   defined   -> round-robin selection starting after the last granted index
//   undefined -> fixed priority, lowest pending bit wins
module four_to_two_enc (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] in,
    input  logic       ready,
    output logic [1:0] y,
    output logic       valid,
    output logic [3:0] pending,
    output logic       drop
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] y_q, y_d;
    logic       valid_q, valid_d;
    logic [3:0] pending_q, pending_d;
    logic       drop_q, drop_d;

    logic       grant_fire;
    logic [1:0] sel_idx;
    logic [3:0] grant_mask;
    logic [3:0] in_cap;

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search upward from the slot after the last grant, wrapping at 4
    always_comb begin
        logic       found;
        logic [1:0] idx;
        sel_idx = 2'd0;
        found   = 1'b0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i + 1);
            if (!found && pending_q[idx]) begin
                sel_idx = idx;
                found   = 1'b1;
            end
        end
    end

    // Pointer follows every grant so the next search starts just past it
    always_comb begin
        ptr_d = ptr_q;
        if (grant_fire) begin
            ptr_d = sel_idx;
        end
    end

    // Pointer register; resets to 3 so the first search starts at index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd3;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest set pending bit wins
    always_comb begin
        sel_idx = 2'd0;
        casez (pending_q)
            4'b???1: sel_idx = 2'd0;
            4'b??10: sel_idx = 2'd1;
            4'b?100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_idx = 2'd0;
        endcase
    end
`endif

    // A grant is issued when the output slot is free (IDLE) or being consumed
    assign grant_fire = (|pending_q) && ((state_q == IDLE) || ready);

    // One-hot mask of the bit leaving pending on this edge
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign grant_mask[gi] = grant_fire && (sel_idx == 2'(gi));
        end
    endgenerate

    assign in_cap = en ? in : 4'b0000;

    // Next pending set, drop detection and handshake state
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        valid_d   = valid_q;
        pending_d = (pending_q & ~grant_mask) | in_cap;
        // A request re-arriving on a bit granted this edge counts as new
        drop_d    = |(in_cap & pending_q & ~grant_mask);
        if (grant_fire) begin
            state_d = HOLD;
            y_d     = sel_idx;
            valid_d = 1'b1;
        end else if ((state_q == HOLD) && ready) begin
            state_d = IDLE;
            y_d     = 2'd0;
            valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards held and pending requests
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= 2'd0;
            valid_q   <= 1'b0;
            pending_q <= 4'b0000;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign y       = y_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign drop    = drop_q;

endmodule

// File: tb/tb_four_to_two_enc.sv
// Scoreboard bench for four_to_two_enc: the driver advances a behavioural
// model each edge and queues the expected outputs; a monitor compares them.
module tb_four_to_two_enc;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] in_s;
    logic       ready;
    logic [1:0] y;
    logic       valid;
    logic [3:0] pending;
    logic       drop;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [1:0] y;
        logic       valid;
        logic [3:0] pending;
        logic       drop;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a set of outstanding requests plus the held grant
    bit m_req[4];
    bit m_busy;
    int m_y;
    int m_last;
    bit m_drop;

    four_to_two_enc dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in      (in_s),
        .ready   (ready),
        .y       (y),
        .valid   (valid),
        .pending (pending),
        .drop    (drop)
    );

    always #5 clk = ~clk;

    function automatic int pick();
        int start;
`ifdef ROUND_ROBIN_EN
        start = (m_last + 1) % 4;
`else
        start = 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (m_req[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r, input bit e, input logic [3:0] i, input bit rd);
        int g;
        exp_t ex;
        if (r) begin
            for (int k = 0; k < 4; k++) m_req[k] = 0;
            m_busy = 0; m_y = 0; m_last = 3; m_drop = 0;
        end else begin
            g = (!m_busy || rd) ? pick() : -1;
            m_drop = 0;
            for (int k = 0; k < 4; k++) begin
                if (e && i[k] && m_req[k] && k != g) m_drop = 1;
            end
            if (g >= 0) m_req[g] = 0;
            for (int k = 0; k < 4; k++) begin
                if (e && i[k]) m_req[k] = 1;
            end
            if (g >= 0) begin
                m_busy = 1; m_y = g; m_last = g;
            end else if (m_busy && rd) begin
                m_busy = 0; m_y = 0;
            end
        end
        ex.y = 2'(m_y);
        ex.valid = m_busy;
        for (int k = 0; k < 4; k++) ex.pending[k] = m_req[k];
        ex.drop = m_drop;
        ex.tag = r ? "reset" : "cycle";
        exp_q.push_back(ex);
    endtask

    // Drive one edge: inputs set, model advanced at the edge, hold #1 after
    task automatic step(input bit r, input bit e, input logic [3:0] i, input bit rd);
        rst = r; en = e; in_s = i; ready = rd;
        @(posedge clk);
        model_edge(r, e, i, rd);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    always @(negedge clk) begin
        exp_t ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            checks++;
            if (y === ex.y && valid === ex.valid && pending === ex.pending && drop === ex.drop) begin
                passed++;
            end else begin
                $display("FAIL %s: got y=%b valid=%b pending=%b drop=%b, required y=%b valid=%b pending=%b drop=%b",
                         ex.tag, y, valid, pending, drop, ex.y, ex.valid, ex.pending, ex.drop);
            end
            if (valid === 1'b1 && ready === 1'b1) begin
                $display("txn: grant y=%b accepted", y);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; in_s = 4'b0; ready = 1'b0;
        // Reset state
        step(1, 0, 4'b0000, 0);
        step(1, 1, 4'b1111, 1);
        // Single request, consumer always ready
        step(0, 1, 4'b0100, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 4'b0000, 1);
        // Three requests at once drain back-to-back
        step(1, 0, 4'b0000, 0);
        step(0, 1, 4'b1011, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0000, 1);
        // All four held for six cycles
        step(1, 0, 4'b0000, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 4'b1111, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 4'b0000, 1);
        // Stall on y=01 and re-request bit 0 twice: second capture drops
        step(1, 0, 4'b0000, 0);
        step(0, 1, 4'b0010, 0);
        step(0, 0, 4'b0000, 0);
        step(0, 1, 4'b0001, 0);
        step(0, 1, 4'b0001, 0);
        step(0, 0, 4'b0000, 0);
        // Re-request the held index: new request, not a drop
        step(0, 1, 4'b0010, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 4'b0000, 1);
        // Capture disabled from IDLE
        step(0, 0, 4'b1111, 1);
        step(0, 0, 4'b1111, 1);
        // Reset while holding y=10 with pending 0011
        step(1, 0, 4'b0000, 0);
        step(0, 1, 4'b0100, 0);
        step(0, 1, 4'b0011, 0);
        step(1, 1, 4'b1111, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 4'b0000, 1);
        // Randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
        end
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/four_to_two_enc.md
FOUR_TO_TWO_ENC -- requirements
Module: four_to_two_enc

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 4 request lines and a 2-bit index.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  request capture enable; 1 = sample in, 0 = ignore in.
REQ-005 in  input  4  request lines, any number hot per cycle; bit k requests index k.
REQ-006 ready  input  1  consumer accepts y this cycle when valid=1.
REQ-007 y  output  2  encoded index of the granted request, registered.
REQ-008 valid  output  1  y holds a granted index, registered.
REQ-009 pending  output  4  registered set of captured, not-yet-granted requests.
REQ-010 drop  output  1  registered one-cycle pulse: a captured request merged into an already-pending bit.

Function
REQ-011 Capture: on each edge with en=1, pending SHALL become (pending & ~grant_mask) | in, where grant_mask is the one-hot bit loaded into y on that edge (else 0).
REQ-012 With en=0, in SHALL be ignored; pending SHALL only lose the bit granted on that edge.
REQ-013 States SHALL be IDLE (valid=0) and HOLD (valid=1).
REQ-014 IDLE: if pending != 0, next edge SHALL load y with the selected index, set valid=1, clear that bit from pending, go to HOLD; else stay IDLE.
REQ-015 HOLD with ready=0: y, valid SHALL hold unchanged.
REQ-016 HOLD with ready=1: if pending != 0 the same edge SHALL load the next selected index (back-to-back, valid stays 1); else valid SHALL go 0, state IDLE.
REQ-017 Selection reads registered pending only; a request on in at edge N is grantable no earlier than edge N+1 (valid 2 edges after in assertion from IDLE).
REQ-018 Encoding SHALL be bit0->00, bit1->01, bit2->10, bit3->11.
REQ-019 A bit of in that is 1 while the same pending bit is 1 and not granted on that edge SHALL set drop=1 for one cycle; the request is merged, not counted.
REQ-020 A request on the index currently held in y (HOLD) SHALL be a new pending request, not a drop.
REQ-021 A request on the bit being granted on the same edge SHALL remain set in pending (new request), not a drop.
REQ-022 y SHALL be 00 whenever valid=0.

Reset
REQ-023 When rst=1 at an edge: y=00, valid=0, pending=0000, drop=0, state IDLE, round-robin pointer=11; rst SHALL override en, in, ready.
REQ-024 Reset mid-HOLD SHALL discard the held index and all pending requests with no grant issued.

Configuration
REQ-025 Macro ROUND_ROBIN_EN defined: selection SHALL search upward from (last granted index + 1) mod 4, wrapping; pointer updates on every grant.
REQ-026 Macro ROUND_ROBIN_EN undefined: fixed priority, lowest set bit of pending wins; no pointer register.

Verification
REQ-027 Reset, then in=0100 one cycle, ready=1 -> valid=1, y=10 two edges after in; valid=0 next edge; pending=0000.
REQ-028 in=1011 one cycle, ready=1, fixed priority -> y sequence 00,01,11 on consecutive cycles, valid continuous 3 cycles.
REQ-029 ROUND_ROBIN_EN, in=1111 held 6 cycles, ready=1 -> y cycles 00,01,10,11,00,...; no index granted twice before all four.
REQ-030 HOLD y=01 ready=0, in=0001 two consecutive cycles -> pending=0001, drop=1 on the second capture only; y stays 01.
REQ-031 en=0 with in=1111 -> pending unchanged, valid stays 0 from IDLE.
REQ-032 HOLD y=10 with pending=0011, assert rst one edge -> valid=0, y=00, pending=0000 next cycle; no further grants.
